// File: rtl/key_debounce.sv
// key_debounce: 2-FF sync plus per-key debounce FSM with one-shot press flags.
// Define KEY_REPEAT_EN for auto-repeat flags while a key is held.
module key_debounce #(
  parameter int CNT_MAX    = 999_999,
  parameter int HOLD_CNT   = 49_999_999,
  parameter int REPEAT_CNT = 9_999_999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key1_in,
  input  logic       key2_in,
  input  logic       key3_in,
  input  logic       key4_in,
  output logic       key1_flag,
  output logic       key2_flag,
  output logic       key3_flag,
  output logic       key4_flag,
  output logic [3:0] key_state
);

  localparam int MAX_AB = (CNT_MAX > HOLD_CNT) ? CNT_MAX : HOLD_CNT;
  localparam int MAX_P  = (MAX_AB > REPEAT_CNT) ? MAX_AB : REPEAT_CNT;
  localparam int CW     = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] CNT_LIM = CW'(CNT_MAX);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_F,
    DOWN,
    REL_F
  } state_t;

  logic [3:0]    raw;
  logic [3:0]    sync1;
  logic [3:0]    key_s;
  logic [3:0]    flag;
  logic [3:0]    flag_nx;
  logic [3:0]    down_lvl;
  state_t        state    [4];
  state_t        state_nx [4];
  logic [CW-1:0] cnt      [4];
  logic [CW-1:0] cnt_nx   [4];

`ifdef KEY_REPEAT_EN
  localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_CNT);
  localparam logic [CW-1:0] RPT_LIM  = CW'(REPEAT_CNT);

  logic [CW-1:0] rpt      [4];
  logic [CW-1:0] rpt_nx   [4];
  logic [3:0]    first;
  logic [3:0]    first_nx;
`endif

  assign raw = {key4_in, key3_in, key2_in, key1_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      key_s <= '1;
      flag  <= '0;
      for (int i = 0; i < 4; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      sync1 <= raw;
      key_s <= sync1;
      flag  <= flag_nx;
      for (int i = 0; i < 4; i++) begin
        state[i] <= state_nx[i];
        cnt[i]   <= cnt_nx[i];
      end
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      first <= '1;
      for (int i = 0; i < 4; i++) begin
        rpt[i] <= '0;
      end
    end else begin
      first <= first_nx;
      for (int i = 0; i < 4; i++) begin
        rpt[i] <= rpt_nx[i];
      end
    end
  end
`endif

  always_comb begin
    flag_nx  = '0;
    down_lvl = '0;
`ifdef KEY_REPEAT_EN
    first_nx = '1;
`endif
    for (int i = 0; i < 4; i++) begin
      state_nx[i] = state[i];
      cnt_nx[i]   = cnt[i];
      down_lvl[i] = (state[i] == DOWN) ||
                    (state[i] == REL_F);
      case (state[i])
        IDLE: begin
          if (!key_s[i]) begin
            state_nx[i] = PRESS_F;
            cnt_nx[i]   = '0;
          end
        end
        PRESS_F: begin
          if (key_s[i]) begin
            state_nx[i] = IDLE;
            cnt_nx[i]   = '0;
          end else if (cnt[i] == CNT_LIM) begin
            state_nx[i] = DOWN;
            flag_nx[i]  = 1'b1;
            cnt_nx[i]   = '0;
          end else begin
            cnt_nx[i] = cnt[i] + 1'b1;
          end
        end
        DOWN: begin
          if (key_s[i]) begin
            state_nx[i] = REL_F;
            cnt_nx[i]   = '0;
          end
        end
        REL_F: begin
          if (!key_s[i]) begin
            state_nx[i] = DOWN;
            cnt_nx[i]   = '0;
          end else if (cnt[i] == CNT_LIM) begin
            state_nx[i] = IDLE;
            cnt_nx[i]   = '0;
          end else begin
            cnt_nx[i] = cnt[i] + 1'b1;
          end
        end
        default: begin
          state_nx[i] = IDLE;
          cnt_nx[i]   = '0;
        end
      endcase
`ifdef KEY_REPEAT_EN
      // Repeat timing only runs while DOWN persists; any exit restarts it.
      rpt_nx[i] = '0;
      if (state[i] == DOWN && state_nx[i] == DOWN) begin
        first_nx[i] = first[i];
        if (first[i] ? (rpt[i] == HOLD_LIM)
                     : (rpt[i] == RPT_LIM)) begin
          flag_nx[i]  = 1'b1;
          first_nx[i] = 1'b0;
        end else begin
          rpt_nx[i] = rpt[i] + 1'b1;
        end
      end
`endif
    end
  end

  assign key1_flag = flag[0];
  assign key2_flag = flag[1];
  assign key3_flag = flag[2];
  assign key4_flag = flag[3];
  assign key_state = down_lvl;

endmodule
